// File: rtl/scan_chain_ctrl_if.sv
// Host and chain-side signals of the scan-chain sequencer.
// master = host plus chain tail (drives requests and scan_out); slave = the controller.
interface scan_chain_ctrl_if #(
  parameter int CHAIN_LEN = 8
);
  logic                 start;
  logic                 capture_en;
  logic [CHAIN_LEN-1:0] load_data;
  logic                 scan_en;
  logic                 scan_in;
  logic                 scan_out;
  logic [CHAIN_LEN-1:0] read_data;
  logic                 busy;
  logic                 done;

  modport master (
    output start, capture_en, load_data, scan_out,
    input  scan_en, scan_in, read_data, busy, done
  );

  modport slave (
    input  start, capture_en, load_data, scan_out,
    output scan_en, scan_in, read_data, busy, done
  );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Serial load/unload sequencer for a mux-scan chain; define SCAN_CAPTURE_EN to add a
// functional capture cycle plus unload pass after the load.
module scan_chain_ctrl #(
  parameter  int CHAIN_LEN = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  scan_chain_ctrl_if.slave   sif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPT,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [CHAIN_LEN-1:0] r_sr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_scan_en;
  logic                 r_scan_in;
  logic                 r_busy;
  logic                 r_done;
  logic [CHAIN_LEN-1:0] r_read_data;

  logic [CHAIN_LEN-1:0] w_sr_next;
  logic                 w_last;

`ifdef SCAN_CAPTURE_EN
  logic                 r_capt;
`else
  logic                 w_unused_capture;
  assign w_unused_capture = sif.capture_en;
`endif

  // scan_out is the tail bit before this edge's shift, so it enters at the top of sr
  assign w_sr_next = {sif.scan_out, r_sr[CHAIN_LEN-1:1]};
  assign w_last    = (r_cnt == CNT_W'(CHAIN_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_scan_en   <= 1'b0;
      r_scan_in   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_read_data <= '0;
`ifdef SCAN_CAPTURE_EN
      r_capt      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (sif.start) begin
            r_sr      <= sif.load_data;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_scan_en <= 1'b1;
            r_scan_in <= sif.load_data[0];
            r_state   <= S_SHIFT;
`ifdef SCAN_CAPTURE_EN
            r_capt    <= sif.capture_en;
`endif
          end
        end

        S_SHIFT: begin
          r_sr <= w_sr_next;
          if (!w_last) begin
            r_cnt     <= r_cnt + CNT_W'(1);
            r_scan_in <= r_sr[1];
          end else begin
            r_cnt     <= '0;
            r_scan_en <= 1'b0;
            r_scan_in <= 1'b0;
`ifdef SCAN_CAPTURE_EN
            if (r_capt) begin
              r_state <= S_CAPT;
            end else begin
              r_read_data <= w_sr_next;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end
`else
            r_read_data <= w_sr_next;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
`endif
          end
        end

`ifdef SCAN_CAPTURE_EN
        // scan_en is low for this one edge, so every flop loads its functional D
        S_CAPT: begin
          r_cnt     <= '0;
          r_scan_en <= 1'b1;
          r_scan_in <= 1'b0;
          r_state   <= S_UNLOAD;
        end

        S_UNLOAD: begin
          r_sr <= w_sr_next;
          if (!w_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt       <= '0;
            r_scan_en   <= 1'b0;
            r_scan_in   <= 1'b0;
            r_read_data <= w_sr_next;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state   <= S_IDLE;
          r_scan_en <= 1'b0;
          r_scan_in <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign sif.scan_en   = r_scan_en;
  assign sif.scan_in   = r_scan_in;
  assign sif.busy      = r_busy;
  assign sif.done      = r_done;
  assign sif.read_data = r_read_data;

  a_scan_in_quiet: assert property (@(posedge clk) disable iff (rst) !r_scan_en |-> !r_scan_in);
  a_done_not_busy: assert property (@(posedge clk) disable iff (rst) r_done |-> !r_busy);

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with an 8-flop mux-scan chain model and a scoreboard queue.
module tb_scan_chain_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  scan_chain_ctrl_if #(.CHAIN_LEN(8)) sif();

  scan_chain_ctrl #(.CHAIN_LEN(8)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  // Chain model: bit 0 is the tail flop, TD of the head is scan_in
  logic [7:0] chain      = 8'h00;
  logic       preset_vld = 1'b0;
  logic [7:0] preset_val = 8'h00;
  logic       func_inv   = 1'b0;

  always @(posedge clk) begin
    if (preset_vld)       chain <= preset_val;
    else if (sif.scan_en) chain <= {sif.scan_in, chain[7:1]};
    else if (func_inv)    chain <= ~chain;
  end

  assign sif.scan_out = chain[0];

  typedef struct {
    logic [7:0] rd;
    logic [7:0] ch;
    int         busy;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic preset_chain(input logic [7:0] v);
    @(negedge clk);
    preset_vld = 1'b1;
    preset_val = v;
    @(negedge clk);
    preset_vld = 1'b0;
  endtask

  // Drives one request and measures it; lat counts cycles from the start cycle (0) to done
  task automatic do_op(input logic [7:0] ld, input logic cap, input logic hold,
                       output int lat, output int busy_c, output int sen_c,
                       output int bad_sin, output logic [7:0] rd, output logic [7:0] ch,
                       output logic done_after, output logic timed_out);
    lat = 0; busy_c = 0; sen_c = 0; bad_sin = 0;
    rd = 8'h00; ch = 8'h00; done_after = 1'b0; timed_out = 1'b1;
    @(negedge clk);
    sif.start      = 1'b1;
    sif.load_data  = ld;
    sif.capture_en = cap;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (!hold) sif.start = 1'b0;
      if (sif.busy) busy_c++;
      if (sif.scan_en) sen_c++;
      if (!sif.scan_en && sif.scan_in) bad_sin++;
      if (sif.done) begin
        rd = sif.read_data;
        ch = chain;
        timed_out = 1'b0;
        break;
      end
    end
    sif.start      = 1'b0;
    sif.capture_en = 1'b0;
    @(negedge clk);
    done_after = sif.done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (sif.scan_en !== 1'b0) begin errors++; $display("FAIL reset_scan_en got=%b want=0", sif.scan_en); end
    checks++; if (sif.scan_in !== 1'b0) begin errors++; $display("FAIL reset_scan_in got=%b want=0", sif.scan_in); end
    checks++; if (sif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", sif.busy); end
    checks++; if (sif.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", sif.done); end
    checks++; if (sif.read_data !== 8'h00) begin errors++; $display("FAIL reset_read_data got=%h want=00", sif.read_data); end
    rst = 1'b0;
  endtask

  // Load A5 over a chain holding 3C, with start held high for the whole operation
  task automatic test_load_held_start();
    int lat, bc, sc, bs, extra;
    logic [7:0] rd, ch;
    logic da, to;
    exp_t e;
    preset_chain(8'h3C);
    sb.push_back('{rd: 8'h3C, ch: 8'hA5, busy: 8});
    do_op(8'hA5, 1'b0, 1'b1, lat, bc, sc, bs, rd, ch, da, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL load_timeout got=%b want=0", to); end
    checks++; if (sb.size() == 0) begin errors++; $display("FAIL load_sb_empty got=0 want=1"); end
    else begin
      e = sb.pop_front();
      checks++; if (rd !== e.rd) begin errors++; $display("FAIL load_read_data got=%h want=%h", rd, e.rd); end
      checks++; if (ch !== e.ch) begin errors++; $display("FAIL load_chain got=%h want=%h", ch, e.ch); end
      checks++; if (bc !== e.busy) begin errors++; $display("FAIL load_busy_cycles got=%0d want=%0d", bc, e.busy); end
    end
    checks++; if (lat !== 9) begin errors++; $display("FAIL load_latency got=%0d want=9", lat); end
    checks++; if (sc !== 8) begin errors++; $display("FAIL load_scan_en_cycles got=%0d want=8", sc); end
    checks++; if (bs !== 0) begin errors++; $display("FAIL load_scan_in_idle got=%0d want=0", bs); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL load_done_width got=%b want=0", da); end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sif.busy || sif.scan_en || sif.done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL held_start_second_op got=%0d want=0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, sc, bs;
    logic [7:0] rd, ch, ld, cur;
    logic da, to;
    exp_t e;
    cur = 8'h96;
    preset_chain(cur);
    for (int k = 0; k < 4; k++) begin
      ld = 8'($urandom_range(0, 255));
      sb.push_back('{rd: cur, ch: ld, busy: 8});
      do_op(ld, 1'b0, 1'b0, lat, bc, sc, bs, rd, ch, da, to);
      checks++; if (to !== 1'b0 || sb.size() == 0) begin errors++; $display("FAIL b2b_timeout op=%0d got=%b want=0", k, to); end
      else begin
        e = sb.pop_front();
        checks++; if (rd !== e.rd) begin errors++; $display("FAIL b2b_read_data op=%0d got=%h want=%h", k, rd, e.rd); end
        checks++; if (ch !== e.ch) begin errors++; $display("FAIL b2b_chain op=%0d got=%h want=%h", k, ch, e.ch); end
        checks++; if (bc !== e.busy || lat !== 9) begin errors++; $display("FAIL b2b_timing op=%0d got=%0d/%0d want=%0d/9", k, bc, lat, e.busy); end
      end
      cur = ld;
    end
  endtask

  task automatic test_reset_mid_shift();
    int seen_done;
    preset_chain(8'h81);
    @(negedge clk);
    sif.start     = 1'b1;
    sif.load_data = 8'h7E;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sif.scan_en !== 1'b1 || sif.busy !== 1'b1) begin errors++; $display("FAIL mid_in_shift got=%b%b want=11", sif.scan_en, sif.busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (sif.scan_en !== 1'b0) begin errors++; $display("FAIL mid_rst_scan_en got=%b want=0", sif.scan_en); end
    checks++; if (sif.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b want=0", sif.busy); end
    checks++; if (sif.scan_in !== 1'b0) begin errors++; $display("FAIL mid_rst_scan_in got=%b want=0", sif.scan_in); end
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (sif.done || sif.busy) seen_done++;
      @(negedge clk);
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL mid_rst_no_done got=%0d want=0", seen_done); end
  endtask

`ifdef SCAN_CAPTURE_EN
  task automatic test_capture();
    int lat, bc, sc, bs;
    logic [7:0] rd, ch;
    logic da, to;
    exp_t e;
    preset_chain(8'h55);
    func_inv = 1'b1;
    sb.push_back('{rd: 8'h0F, ch: 8'h00, busy: 17});
    do_op(8'hF0, 1'b1, 1'b0, lat, bc, sc, bs, rd, ch, da, to);
    func_inv = 1'b0;
    checks++; if (to !== 1'b0 || sb.size() == 0) begin errors++; $display("FAIL capt_timeout got=%b want=0", to); end
    else begin
      e = sb.pop_front();
      checks++; if (rd !== e.rd) begin errors++; $display("FAIL capt_read_data got=%h want=%h", rd, e.rd); end
      checks++; if (ch !== e.ch) begin errors++; $display("FAIL capt_chain got=%h want=%h", ch, e.ch); end
      checks++; if (bc !== e.busy) begin errors++; $display("FAIL capt_busy_cycles got=%0d want=%0d", bc, e.busy); end
    end
    checks++; if (sc !== 16) begin errors++; $display("FAIL capt_scan_en_cycles got=%0d want=16", sc); end
    checks++; if (bs !== 0) begin errors++; $display("FAIL capt_scan_in_idle got=%0d want=0", bs); end
  endtask
`else
  task automatic test_capture();
    int lat, bc, sc, bs;
    logic [7:0] rd, ch;
    logic da, to;
    exp_t e;
    preset_chain(8'h3C);
    sb.push_back('{rd: 8'h3C, ch: 8'hA5, busy: 8});
    do_op(8'hA5, 1'b1, 1'b0, lat, bc, sc, bs, rd, ch, da, to);
    checks++; if (to !== 1'b0 || sb.size() == 0) begin errors++; $display("FAIL nocapt_timeout got=%b want=0", to); end
    else begin
      e = sb.pop_front();
      checks++; if (rd !== e.rd) begin errors++; $display("FAIL nocapt_read_data got=%h want=%h", rd, e.rd); end
      checks++; if (ch !== e.ch) begin errors++; $display("FAIL nocapt_chain got=%h want=%h", ch, e.ch); end
      checks++; if (bc !== e.busy) begin errors++; $display("FAIL nocapt_busy_cycles got=%0d want=%0d", bc, e.busy); end
    end
    checks++; if (lat !== 9 || sc !== 8) begin errors++; $display("FAIL nocapt_timing got=%0d/%0d want=9/8", lat, sc); end
  endtask
`endif

  initial begin
    sif.start      = 1'b0;
    sif.capture_en = 1'b0;
    sif.load_data  = 8'h00;
    test_reset();
    test_load_held_start();
    test_back_to_back();
    test_reset_mid_shift();
    test_capture();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
